mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit_if.sv | 22 ++
 rtl/mem_access_unit.sv | 149 ++++++++++++++
 tb/tb_mem_access_unit.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
// Memory bus between the MEM-stage access unit and the data memory.
// There is one request channel with a ready handshake and one single-pulse load response channel.
interface mem_access_unit_if;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_we;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_wdata;
  logic [3:0]  mem_req_be;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_rdata;

  modport master (
    output mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_be,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata
  );

  modport slave (
    input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_be,
    output mem_req_ready, mem_rsp_valid, mem_rsp_rdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: it checks alignment, drives bus lanes, stalls the pipeline while loads are outstanding,
// and forces completion with a bus error when a load response never arrives.
module mem_access_unit #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                e_MemRead,
  input  logic                e_MemWrite,
  input  logic [2:0]          e_funct3,
  input  logic [31:0]         e_addr,
  input  logic [31:0]         e_wdata,
  mem_access_unit_if.master   mem,
  output logic                stall,
  output logic [31:0]         m_read_data,
  output logic                access_fault,
  output logic                bus_error
);

  typedef enum logic {IDLE, WAIT_RSP} state_t;

  localparam logic [7:0] TIMEOUT_VAL = 8'(TIMEOUT_CYC);

  state_t      state_reg, state_next;
  logic [7:0]  cnt_reg, cnt_next;
  logic [1:0]  off_reg, off_next;
  logic [2:0]  f3_reg, f3_next;
  logic [31:0] rdata_reg, rdata_next;
  logic        berr_reg, berr_next;

  logic        access_present;
  logic        illegal_f3;
  logic        misaligned;
  logic [31:0] load_fmt;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  assign access_present = e_MemRead | e_MemWrite;
  assign illegal_f3     = (e_funct3 == 3'b011) || (e_funct3 == 3'b110) || (e_funct3 == 3'b111);
  assign misaligned     = ((e_funct3[1:0] == 2'b01) && e_addr[0]) ||
                          ((e_funct3 == 3'b010) && (e_addr[1:0] != 2'b00));
  assign access_fault   = access_present & (illegal_f3 | misaligned);

  // The lane steering depends only on the live MEM-stage inputs, so it stays stable while the pipeline is stalled.
  assign mem.mem_req_addr = {e_addr[31:2], 2'b00};
  assign mem.mem_req_we   = e_MemWrite;

  always_comb begin
    mem.mem_req_be    = 4'b1111;
    mem.mem_req_wdata = e_wdata;
    case (e_funct3[1:0])
      2'b00: begin
        mem.mem_req_be    = 4'b0001 << e_addr[1:0];
        mem.mem_req_wdata = {4{e_wdata[7:0]}};
      end
      2'b01: begin
        mem.mem_req_be    = e_addr[1] ? 4'b1100 : 4'b0011;
        mem.mem_req_wdata = {2{e_wdata[15:0]}};
      end
      default: begin
        mem.mem_req_be    = 4'b1111;
        mem.mem_req_wdata = e_wdata;
      end
    endcase
  end

  // The response is formatted with the offset and size latched at the handshake, not the live inputs.
  always_comb begin
    sel_half = off_reg[1] ? mem.mem_rsp_rdata[31:16] : mem.mem_rsp_rdata[15:0];
    case (off_reg)
      2'd0:    sel_byte = mem.mem_rsp_rdata[7:0];
      2'd1:    sel_byte = mem.mem_rsp_rdata[15:8];
      2'd2:    sel_byte = mem.mem_rsp_rdata[23:16];
      default: sel_byte = mem.mem_rsp_rdata[31:24];
    endcase
    case (f3_reg)
      3'b000:  load_fmt = {{24{sel_byte[7]}}, sel_byte};
      3'b001:  load_fmt = {{16{sel_half[15]}}, sel_half};
      3'b100:  load_fmt = {24'h0, sel_byte};
      3'b101:  load_fmt = {16'h0, sel_half};
      default: load_fmt = mem.mem_rsp_rdata;
    endcase
  end

  always_comb begin
    state_next        = state_reg;
    cnt_next          = cnt_reg;
    off_next          = off_reg;
    f3_next           = f3_reg;
    rdata_next        = rdata_reg;
    berr_next         = 1'b0;
    stall             = 1'b0;
    mem.mem_req_valid = 1'b0;
    case (state_reg)
      IDLE: begin
        mem.mem_req_valid = access_present & ~access_fault;
        if (mem.mem_req_valid) begin
          if (e_MemWrite) begin
            stall = ~mem.mem_req_ready;
          end else begin
            stall = 1'b1;
            if (mem.mem_req_ready) begin
              off_next   = e_addr[1:0];
              f3_next    = e_funct3;
              cnt_next   = 8'd0;
              state_next = WAIT_RSP;
            end
          end
        end
      end
      WAIT_RSP: begin
        if (mem.mem_rsp_valid) begin
          rdata_next = load_fmt;
          state_next = IDLE;
        end else if (cnt_reg == TIMEOUT_VAL) begin
          rdata_next = 32'h0;
          berr_next  = 1'b1;
          state_next = IDLE;
        end else begin
          stall    = 1'b1;
          cnt_next = cnt_reg + 8'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= 8'd0;
      off_reg   <= 2'd0;
      f3_reg    <= 3'd0;
      rdata_reg <= 32'h0;
      berr_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      off_reg   <= off_next;
      f3_reg    <= f3_next;
      rdata_reg <= rdata_next;
      berr_reg  <= berr_next;
    end
  end

  assign m_read_data = rdata_reg;
  assign bus_error   = berr_reg;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: directed vectors push the expected requests and load results,
// and a monitor compares them against what the unit actually presents.
module tb_mem_access_unit;
  localparam int TO = 6;

  logic        clk;
  logic        rst_n;
  logic        e_MemRead, e_MemWrite;
  logic [2:0]  e_funct3;
  logic [31:0] e_addr, e_wdata;
  logic        stall, access_fault, bus_error;
  logic [31:0] m_read_data;

  mem_access_unit_if bus();

  mem_access_unit #(.TIMEOUT_CYC(TO)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .e_MemRead    (e_MemRead),
    .e_MemWrite   (e_MemWrite),
    .e_funct3     (e_funct3),
    .e_addr       (e_addr),
    .e_wdata      (e_wdata),
    .mem          (bus.master),
    .stall        (stall),
    .m_read_data  (m_read_data),
    .access_fault (access_fault),
    .bus_error    (bus_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } req_t;

  typedef struct {
    logic [31:0] res;
    logic        berr;
  } res_t;

  typedef struct {
    logic        rd, wr;
    logic [2:0]  f3;
    logic [31:0] addr, wdata;
    int          ready_low, rsp_delay;
    logic [31:0] rsp_word;
    logic        exp_fault;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata, exp_res;
    logic        exp_berr;
    int          exp_stall;
  } vec_t;

  req_t exp_req_q[$];
  res_t exp_res_q[$];
  vec_t vq[$];

  int          n_checks = 0;
  int          n_pass   = 0;
  int          rsp_delay_g = -1;
  logic [31:0] rsp_word_g  = 32'h0;
  logic [31:0] last_res    = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h required=%h", name, act, exp);
  endtask

  task automatic add_vec(input logic rd, wr, input logic [2:0] f3, input logic [31:0] addr, wdata,
                         input int ready_low, rsp_delay, input logic [31:0] rsp_word,
                         input logic exp_fault, input logic [31:0] exp_addr, input logic [3:0] exp_be,
                         input logic [31:0] exp_wdata, exp_res, input logic exp_berr, input int exp_stall);
    vec_t v;
    v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = addr; v.wdata = wdata;
    v.ready_low = ready_low; v.rsp_delay = rsp_delay; v.rsp_word = rsp_word;
    v.exp_fault = exp_fault; v.exp_addr = exp_addr; v.exp_be = exp_be;
    v.exp_wdata = exp_wdata; v.exp_res = exp_res; v.exp_berr = exp_berr; v.exp_stall = exp_stall;
    vq.push_back(v);
  endtask

  // Memory responder: a single response pulse rsp_delay_g cycles after the cycle that follows the load handshake.
  initial begin
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (rst_n && bus.mem_req_valid && bus.mem_req_ready && !bus.mem_req_we && rsp_delay_g >= 0) begin
        repeat (rsp_delay_g) @(posedge clk);
        @(posedge clk); #1;
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_rdata = rsp_word_g;
        @(posedge clk); #1;
        bus.mem_rsp_valid = 1'b0;
      end
    end
  end

  // Monitor: request handshakes and completed loads are popped from the scoreboard.
  initial begin
    bit res_pending = 0;
    req_t r;
    res_t e;
    forever begin
      @(negedge clk);
      if (res_pending) begin
        res_pending = 0;
        if (exp_res_q.size() == 0) check("res_q_underflow", 1, 0);
        else begin
          e = exp_res_q.pop_front();
          check("m_read_data", m_read_data, e.res);
          check("bus_error", {31'h0, bus_error}, {31'h0, e.berr});
        end
      end
      if (rst_n && bus.mem_req_valid && bus.mem_req_ready) begin
        if (exp_req_q.size() == 0) check("req_q_underflow", 1, 0);
        else begin
          r = exp_req_q.pop_front();
          $display("req we=%0b addr=%h be=%b wdata=%h", bus.mem_req_we, bus.mem_req_addr, bus.mem_req_be, bus.mem_req_wdata);
          check("req_we", {31'h0, bus.mem_req_we}, {31'h0, r.we});
          check("req_addr", bus.mem_req_addr, r.addr);
          check("req_be", {28'h0, bus.mem_req_be}, {28'h0, r.be});
          if (r.we) check("req_wdata", bus.mem_req_wdata, r.wdata);
        end
      end
      if (rst_n && !stall && e_MemRead && !access_fault) res_pending = 1;
    end
  end

  task automatic issue(input vec_t v, output int stall_cyc, output int valid_cyc, output logic fault_seen);
    req_t r;
    res_t e;
    bit done = 0;
    e_MemRead  = v.rd;
    e_MemWrite = v.wr;
    e_funct3   = v.f3;
    e_addr     = v.addr;
    e_wdata    = v.wdata;
    rsp_delay_g = v.rsp_delay;
    rsp_word_g  = v.rsp_word;
    bus.mem_req_ready = (v.ready_low == 0);
    if (!v.exp_fault) begin
      r.we = v.wr; r.addr = v.exp_addr; r.be = v.exp_be; r.wdata = v.exp_wdata;
      exp_req_q.push_back(r);
      if (v.rd) begin
        e.res = v.exp_res; e.berr = v.exp_berr;
        exp_res_q.push_back(e);
      end
    end
    stall_cyc = 0;
    valid_cyc = 0;
    fault_seen = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (c == 0) fault_seen = access_fault;
      if (bus.mem_req_valid) valid_cyc++;
      if (!stall) begin
        done = 1;
        break;
      end
      stall_cyc++;
      @(posedge clk); #1;
      if (stall_cyc >= v.ready_low) bus.mem_req_ready = 1'b1;
    end
    if (!done) check("stall_bound", 1, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    int sc, vc, exp_vc;
    logic fs;
    vec_t v;
    rst_n = 1'b0;
    e_MemRead = 0; e_MemWrite = 0; e_funct3 = 3'b000; e_addr = 32'h0; e_wdata = 32'h0;
    bus.mem_req_ready = 1'b0;

    //       rd wr f3      addr          wdata         rl d   rsp_word      flt exp_addr      be       exp_wdata     exp_res       berr stall
    add_vec(1, 0, 3'b000, 32'h0000_1003, 32'h0,        0, 0, 32'h80FF_1234, 0, 32'h0000_1000, 4'b1000, 32'h0,        32'hFFFF_FF80, 0, 1);
    add_vec(0, 1, 3'b001, 32'h0000_2002, 32'h0000_ABCD, 3, -1, 32'h0,       0, 32'h0000_2000, 4'b1100, 32'hABCD_ABCD, 32'h0,        0, 3);
    add_vec(1, 0, 3'b010, 32'h0000_3001, 32'h0,        0, -1, 32'h0,        1, 32'h0,        4'b0000, 32'h0,        32'h0,        0, 0);
    add_vec(1, 0, 3'b101, 32'h0000_4002, 32'h0,        0, 5, 32'h9ABC_0000, 0, 32'h0000_4000, 4'b1100, 32'h0,        32'h0000_9ABC, 0, 6);
    add_vec(0, 1, 3'b000, 32'h0000_5001, 32'h1234_5677, 0, -1, 32'h0,       0, 32'h0000_5000, 4'b0010, 32'h7777_7777, 32'h0,        0, 0);
    add_vec(1, 0, 3'b001, 32'h0000_1002, 32'h0,        0, 0, 32'h8001_0000, 0, 32'h0000_1000, 4'b1100, 32'h0,        32'hFFFF_8001, 0, 1);
    add_vec(1, 0, 3'b100, 32'h0000_1001, 32'h0,        0, 2, 32'h0000_F000, 0, 32'h0000_1000, 4'b0010, 32'h0,        32'h0000_00F0, 0, 3);
    add_vec(0, 1, 3'b010, 32'h0000_6000, 32'hDEAD_BEEF, 1, -1, 32'h0,       0, 32'h0000_6000, 4'b1111, 32'hDEAD_BEEF, 32'h0,        0, 1);
    add_vec(0, 1, 3'b001, 32'h0000_2001, 32'h0000_1111, 0, -1, 32'h0,       1, 32'h0,        4'b0000, 32'h0,        32'h0,        0, 0);
    add_vec(0, 1, 3'b011, 32'h0000_0000, 32'h0000_2222, 0, -1, 32'h0,       1, 32'h0,        4'b0000, 32'h0,        32'h0,        0, 0);
    add_vec(1, 0, 3'b000, 32'h0000_9000, 32'h0,        0, 0, 32'h0000_007F, 0, 32'h0000_9000, 4'b0001, 32'h0,        32'h0000_007F, 0, 1);
    // No response: the handshake cycle plus TO waiting cycles stall, then completion is forced.
    add_vec(1, 0, 3'b010, 32'h0000_7000, 32'h0,        0, -1, 32'h0,        0, 32'h0000_7000, 4'b1111, 32'h0,        32'h0,        1, 7);
    add_vec(1, 0, 3'b010, 32'h0000_8004, 32'h0,        0, 0, 32'h1234_5678, 0, 32'h0000_8004, 4'b1111, 32'h0,        32'h1234_5678, 0, 1);

    @(negedge clk);
    check("rst_req_valid", {31'h0, bus.mem_req_valid}, 0);
    check("rst_stall", {31'h0, stall}, 0);
    check("rst_read_data", m_read_data, 0);
    check("rst_bus_error", {31'h0, bus_error}, 0);
    check("rst_fault", {31'h0, access_fault}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vq[i]) begin
      v = vq[i];
      issue(v, sc, vc, fs);
      exp_vc = v.exp_fault ? 0 : (v.wr ? v.ready_low + 1 : 1);
      $display("vec %0d rd=%0b wr=%0b f3=%b addr=%h stall=%0d valid=%0d fault=%0b", i, v.rd, v.wr, v.f3, v.addr, sc, vc, fs);
      check($sformatf("v%0d_fault", i), {31'h0, fs}, {31'h0, v.exp_fault});
      check($sformatf("v%0d_stall_cyc", i), sc, v.exp_stall);
      check($sformatf("v%0d_valid_cyc", i), vc, exp_vc);
      if (v.exp_fault) check($sformatf("v%0d_read_held", i), m_read_data, last_res);
      if (v.rd && !v.exp_fault) last_res = v.exp_res;
      if (v.exp_berr) begin
        e_MemRead = 0; e_MemWrite = 0;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        check("bus_error_one_cycle", {31'h0, bus_error}, 0);
        @(posedge clk); #1;
      end
    end

    // A load is abandoned by reset while it waits for a response, and the response that arrives late is ignored.
    begin
      req_t r;
      rsp_delay_g = -1;
      r.we = 0; r.addr = 32'h0000_8008; r.be = 4'b1111; r.wdata = 32'h0;
      exp_req_q.push_back(r);
      e_MemRead = 1; e_MemWrite = 0; e_funct3 = 3'b010; e_addr = 32'h0000_8008;
      bus.mem_req_ready = 1'b1;
      @(negedge clk);
      check("abandon_hs_stall", {31'h0, stall}, 1);
      @(posedge clk); #1;
      @(negedge clk);
      check("abandon_wait_stall", {31'h0, stall}, 1);
      @(posedge clk); #1;
      rst_n = 1'b0;
      e_MemRead = 0;
      @(negedge clk);
      $display("reset during wait stall=%0b read_data=%h", stall, m_read_data);
      check("rst_wait_stall", {31'h0, stall}, 0);
      check("rst_wait_read_data", m_read_data, 0);
      check("rst_wait_req_valid", {31'h0, bus.mem_req_valid}, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      bus.mem_rsp_valid = 1'b1;
      bus.mem_rsp_rdata = 32'hCAFE_F00D;
      @(negedge clk);
      check("late_rsp_stall", {31'h0, stall}, 0);
      @(posedge clk); #1;
      bus.mem_rsp_valid = 1'b0;
      @(negedge clk);
      $display("late response read_data=%h bus_error=%0b", m_read_data, bus_error);
      check("late_rsp_read_data", m_read_data, 0);
      check("late_rsp_bus_error", {31'h0, bus_error}, 0);
      @(posedge clk); #1;
    end

    v = vq[10];
    issue(v, sc, vc, fs);
    check("post_rst_stall_cyc", sc, 1);
    e_MemRead = 0; e_MemWrite = 0;
    repeat (3) @(posedge clk);
    #1;
    check("req_q_empty", exp_req_q.size(), 0);
    check("res_q_empty", exp_res_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
